// File: rtl/rcv_pkg.sv
// Shared types and constants for the serial receive controller.
// Imported by rcv_ctrl; holds the FSM state encoding and the default bit period.
package rcv_pkg;

   localparam int unsigned ClksPerBitDefault = 10;

   // Zero-based index of the last sampled bit in a frame (8 data bits + stop).
   localparam logic [3:0] LastBitIdx = 4'd8;

   typedef enum logic [2:0] {
      StIdle,
      StStartChk,
      StReceive,
      StStopChk,
      StLoad
   } rcv_state_e;

endpackage

// File: rtl/rcv_timer.sv
// Clock-within-bit counter and bit counter for the receive controller.
// strobe fires in the cycle the clock count reaches rollover; the count then wraps.
module rcv_timer #(
   parameter int unsigned CntWidth = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clear,
   input  logic                enable,
   input  logic [CntWidth-1:0] rollover,
   output logic [3:0]          bit_cnt,
   output logic                strobe
);

   logic [CntWidth-1:0] clk_cnt_q, clk_cnt_d;
   logic [3:0]          bit_cnt_q, bit_cnt_d;

   always_comb begin
      strobe    = enable && (clk_cnt_q == rollover);
      clk_cnt_d = clk_cnt_q;
      bit_cnt_d = bit_cnt_q;
      // clear wins over counting so a state change always restarts the period
      if (clear) begin
         clk_cnt_d = '0;
         bit_cnt_d = '0;
      end else if (strobe) begin
         clk_cnt_d = '0;
         bit_cnt_d = bit_cnt_q + 4'd1;
      end else if (enable) begin
         clk_cnt_d = clk_cnt_q + CntWidth'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clk_cnt_q <= '0;
         bit_cnt_q <= '0;
      end else begin
         clk_cnt_q <= clk_cnt_d;
         bit_cnt_q <= bit_cnt_d;
      end
   end

   assign bit_cnt = bit_cnt_q;

endmodule

// File: rtl/rcv_ctrl.sv
// Receive-side control for an asynchronous serial line: start validation, bit-centre
// strobes for an external shift register, stop-bit check and receive-buffer handshake.
module rcv_ctrl
   import rcv_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = ClksPerBitDefault
) (
   input  logic clk,
   input  logic rst,
   input  logic serial_in,
   input  logic stop_bit,
   input  logic data_read,
   output logic shift_strobe,
   output logic packet_done,
   output logic load_buffer,
   output logic data_ready,
   output logic framing_error,
   output logic overrun_error
);

   localparam int unsigned CntWidth = $clog2(CLKS_PER_BIT);
   localparam logic [CntWidth-1:0] BitLast  = CntWidth'(CLKS_PER_BIT - 1);
   localparam logic [CntWidth-1:0] HalfLast = CntWidth'(CLKS_PER_BIT / 2 - 1);

   logic       sync1_q, sync2_q, hist_q;
   logic       line_fall;
   rcv_state_e state_q;

   logic                tmr_clear, tmr_enable, tmr_strobe;
   logic [CntWidth-1:0] tmr_rollover;
   logic [3:0]          bit_cnt;

   logic packet_done_q, load_buffer_q, data_ready_q, framing_error_q, overrun_error_q;

   // Preset to 1 so reset looks like an idle line and never fakes a start edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         hist_q  <= 1'b1;
      end else begin
         sync1_q <= serial_in;
         sync2_q <= sync1_q;
         hist_q  <= sync2_q;
      end
   end

   assign line_fall = hist_q & ~sync2_q;

   // START_CHK counts to the half-bit point; RECEIVE counts full bit periods.
   always_comb begin
      tmr_enable   = (state_q == StStartChk) || (state_q == StReceive);
      tmr_clear    = (state_q == StIdle) || ((state_q == StStartChk) && tmr_strobe);
      tmr_rollover = (state_q == StStartChk) ? HalfLast : BitLast;
   end

   rcv_timer #(
      .CntWidth (CntWidth)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .clear    (tmr_clear),
      .enable   (tmr_enable),
      .rollover (tmr_rollover),
      .bit_cnt  (bit_cnt),
      .strobe   (tmr_strobe)
   );

   assign shift_strobe = tmr_strobe && (state_q == StReceive);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= StIdle;
         packet_done_q   <= 1'b0;
         load_buffer_q   <= 1'b0;
         data_ready_q    <= 1'b0;
         framing_error_q <= 1'b0;
         overrun_error_q <= 1'b0;
      end else begin
         packet_done_q <= 1'b0;
         load_buffer_q <= 1'b0;
         if (data_read) begin
            data_ready_q    <= 1'b0;
            overrun_error_q <= 1'b0;
         end
         unique case (state_q)
            StIdle: begin
               if (line_fall) state_q <= StStartChk;
            end
            StStartChk: begin
               if (tmr_strobe) begin
                  if (!sync2_q) begin
                     state_q         <= StReceive;
                     framing_error_q <= 1'b0;
                  end else begin
                     state_q <= StIdle;
                  end
               end
            end
            StReceive: begin
               if (shift_strobe && (bit_cnt == LastBitIdx)) begin
                  state_q       <= StStopChk;
                  packet_done_q <= 1'b1;
               end
            end
            StStopChk: begin
               if (stop_bit) begin
                  state_q       <= StLoad;
                  load_buffer_q <= 1'b1;
               end else begin
                  state_q         <= StIdle;
                  framing_error_q <= 1'b1;
               end
            end
            StLoad: begin
               // A read in the load cycle consumes the old byte, so the new one is no overrun.
               data_ready_q    <= 1'b1;
               overrun_error_q <= !data_read && (overrun_error_q || data_ready_q);
               state_q         <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign packet_done   = packet_done_q;
   assign load_buffer   = load_buffer_q;
   assign data_ready    = data_ready_q;
   assign framing_error = framing_error_q;
   assign overrun_error = overrun_error_q;

endmodule

// File: tb/tb_rcv_ctrl.sv
// Directed self-checking bench for rcv_ctrl at CLKS_PER_BIT = 10.
module tb_rcv_ctrl;

   localparam int unsigned Cpb = 10;

   logic clk, rst, serial_in, stop_bit, data_read;
   logic shift_strobe, packet_done, load_buffer, data_ready, framing_error, overrun_error;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int strobe_q[$];
   int pd_n, lb_n, pd_cyc, lb_cyc;
   int k;

   rcv_ctrl #(
      .CLKS_PER_BIT (Cpb)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .serial_in     (serial_in),
      .stop_bit      (stop_bit),
      .data_read     (data_read),
      .shift_strobe  (shift_strobe),
      .packet_done   (packet_done),
      .load_buffer   (load_buffer),
      .data_ready    (data_ready),
      .framing_error (framing_error),
      .overrun_error (overrun_error)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (shift_strobe) strobe_q.push_back(cyc);
      if (packet_done) begin
         pd_n++;
         pd_cyc = cyc;
      end
      if (load_buffer) begin
         lb_n++;
         lb_cyc = cyc;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_mon();
      strobe_q.delete();
      pd_n   = 0;
      lb_n   = 0;
      pd_cyc = -1;
      lb_cyc = -1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Drives start, 8 data bits LSB first and the stop bit. Called at a negedge.
   // rd_off > 0 raises data_read for the one cycle at start + rd_off.
   // abort_at > 0 asserts rst at that shift_strobe and returns with rst held.
   task automatic send_frame(input logic [7:0] data, input logic stop_v, input int abort_at,
                             input int rd_off, output int start_c);
      logic [9:0] bits;
      int         seen;
      bit         aborted;
      bits    = {stop_v, data, 1'b0};
      seen    = 0;
      aborted = 1'b0;
      stop_bit = stop_v;
      start_c  = cyc;
      for (int b = 0; b < 10 && !aborted; b++) begin
         serial_in = bits[b];
         for (int c = 0; c < int'(Cpb) && !aborted; c++) begin
            @(negedge clk);
            if (rd_off > 0) data_read = (cyc == start_c + rd_off);
            if (abort_at > 0 && shift_strobe) begin
               seen++;
               if (seen == abort_at) begin
                  rst       = 1'b1;
                  serial_in = 1'b1;
                  aborted   = 1'b1;
                  #1;
               end
            end
         end
      end
   endtask

   task automatic check_good_frame(input string tag, input int start_c);
      int first;
      first = (strobe_q.size() > 0) ? strobe_q[0] : -1;
      check({tag, "_strobes"}, strobe_q.size(), 9);
      check({tag, "_first_strobe"}, first, start_c + 17);
      for (int i = 1; i < strobe_q.size(); i++)
         check({tag, "_strobe_gap"}, strobe_q[i] - strobe_q[i-1], Cpb);
      check({tag, "_pd_count"}, pd_n, 1);
      check({tag, "_pd_cycle"}, pd_cyc, start_c + 98);
      check({tag, "_lb_count"}, lb_n, 1);
      check({tag, "_lb_cycle"}, lb_cyc, start_c + 99);
   endtask

   initial begin
      rst       = 1'b1;
      serial_in = 1'b1;
      stop_bit  = 1'b1;
      data_read = 1'b0;
      clear_mon();
      idle(3);
      check("rst_strobe", shift_strobe, 0);
      check("rst_pd", packet_done, 0);
      check("rst_lb", load_buffer, 0);
      check("rst_dr", data_ready, 0);
      check("rst_fe", framing_error, 0);
      check("rst_oe", overrun_error, 0);
      rst = 1'b0;
      idle(5);

      // Three-clock low glitch is rejected at the half-bit sample.
      clear_mon();
      serial_in = 1'b0;
      idle(3);
      serial_in = 1'b1;
      idle(20);
      check("glitch_strobes", strobe_q.size(), 0);
      check("glitch_pd", pd_n, 0);
      check("glitch_lb", lb_n, 0);
      check("glitch_dr", data_ready, 0);
      check("glitch_fe", framing_error, 0);
      check("glitch_oe", overrun_error, 0);

      // Good frame 0xA5.
      clear_mon();
      send_frame(8'hA5, 1'b1, 0, 0, k);
      idle(3);
      check_good_frame("a5", k);
      check("a5_dr", data_ready, 1);
      check("a5_fe", framing_error, 0);
      check("a5_oe", overrun_error, 0);

      // Stop bit 0, line then held low: framing error, no load, no new frame.
      clear_mon();
      send_frame(8'h5A, 1'b0, 0, 0, k);
      idle(3);
      check("fe_strobes", strobe_q.size(), 9);
      check("fe_pd_count", pd_n, 1);
      check("fe_pd_cycle", pd_cyc, k + 98);
      check("fe_lb_count", lb_n, 0);
      check("fe_fe", framing_error, 1);
      check("fe_dr_unchanged", data_ready, 1);
      check("fe_oe", overrun_error, 0);
      clear_mon();
      idle(40);
      check("held_low_strobes", strobe_q.size(), 0);
      check("held_low_pd", pd_n, 0);
      check("held_low_fe", framing_error, 1);
      serial_in = 1'b1;
      idle(5);

      // Second good load without a read: overrun; framing error cleared by the valid start.
      clear_mon();
      stop_bit = 1'b1;
      send_frame(8'hC3, 1'b1, 0, 0, k);
      idle(3);
      check_good_frame("c3", k);
      check("c3_fe_cleared", framing_error, 0);
      check("c3_dr", data_ready, 1);
      check("c3_oe", overrun_error, 1);
      data_read = 1'b1;
      idle(1);
      data_read = 1'b0;
      idle(2);
      check("read_dr", data_ready, 0);
      check("read_oe", overrun_error, 0);

      // data_read coincident with load_buffer while data_ready is set.
      clear_mon();
      send_frame(8'h0F, 1'b1, 0, 0, k);
      idle(3);
      check("0f_dr", data_ready, 1);
      check("0f_oe", overrun_error, 0);
      clear_mon();
      send_frame(8'hF0, 1'b1, 0, 99, k);
      idle(3);
      check_good_frame("f0", k);
      check("coinc_dr", data_ready, 1);
      check("coinc_oe", overrun_error, 0);

      // Reset at the 4th strobe aborts the frame immediately.
      clear_mon();
      send_frame(8'h96, 1'b1, 4, 0, k);
      check("abort_strobe", shift_strobe, 0);
      check("abort_pd", packet_done, 0);
      check("abort_lb", load_buffer, 0);
      check("abort_dr", data_ready, 0);
      check("abort_fe", framing_error, 0);
      check("abort_oe", overrun_error, 0);
      @(negedge clk);
      rst = 1'b0;
      clear_mon();
      idle(120);
      check("post_abort_strobes", strobe_q.size(), 0);
      check("post_abort_pd", pd_n, 0);
      check("post_abort_lb", lb_n, 0);

      // Normal reception after the aborted frame.
      clear_mon();
      send_frame(8'h3C, 1'b1, 0, 0, k);
      idle(3);
      check_good_frame("3c", k);
      check("3c_dr", data_ready, 1);
      check("3c_fe", framing_error, 0);
      check("3c_oe", overrun_error, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/rcv_ctrl.md
RCV_CTRL -- requirements
Module: rcv_ctrl

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 10, meaning clocks per serial bit period (legal range 4..1023).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; one clock, reset asynchronous and active-high.
REQ-004 SHALL have port serial_in  input  1  raw asynchronous receive line, idle high.
REQ-005 SHALL have port stop_bit  input  1  stop bit from the downstream 9-bit shift register.
REQ-006 SHALL have port data_read  input  1  consumer acknowledge of buffered byte.
REQ-007 SHALL have port shift_strobe  output  1  one-cycle pulse at each bit centre, feeding the shift register.
REQ-008 SHALL have port packet_done  output  1  one-cycle pulse after the 9th shift_strobe.
REQ-009 SHALL have port load_buffer  output  1  one-cycle pulse loading the received byte into the receive buffer.
REQ-010 SHALL have port data_ready  output  1  buffered byte valid, level.
REQ-011 SHALL have port framing_error  output  1  last frame had stop bit 0, level.
REQ-012 SHALL have port overrun_error  output  1  byte loaded while data_ready already set, level.

Function
REQ-013 SHALL pass serial_in through two synchronizer flops plus one edge-history flop; start detection uses only the synchronized value.
REQ-014 SHALL implement states IDLE, START_CHK, RECEIVE, STOP_CHK, LOAD.
REQ-015 IDLE -> START_CHK when the synchronized line goes 1 to 0; clock counter cleared on entry.
REQ-016 In START_CHK, at the cycle where clock count equals CLKS_PER_BIT/2 - 1 (integer division): line 0 -> RECEIVE with counters cleared and framing_error cleared; line 1 -> IDLE (glitch rejected, no strobe).
REQ-017 In RECEIVE, shift_strobe SHALL assert exactly in the cycle where clock count equals CLKS_PER_BIT-1; the count then wraps to 0 and the bit counter increments.
REQ-018 After the 9th shift_strobe (8 data + stop), SHALL enter STOP_CHK on the next cycle; no further strobes.
REQ-019 STOP_CHK lasts one cycle with packet_done=1 and samples stop_bit: 1 -> LOAD; 0 -> set framing_error, no load_buffer, go IDLE.
REQ-020 LOAD lasts one cycle with load_buffer=1, sets data_ready, then goes IDLE.
REQ-021 If data_ready=1 and data_read=0 in the LOAD cycle, SHALL set overrun_error.
REQ-022 data_read=1 SHALL clear data_ready and overrun_error on the next edge, except a simultaneous LOAD keeps data_ready=1 and sets no overrun.
REQ-023 Start detection SHALL require a fresh 1-to-0 edge; a line held low after a framing error starts no frame.
REQ-024 Bit counter width 4 bits; clock counter width $clog2(CLKS_PER_BIT).

Reset
REQ-025 rst=1 SHALL immediately force state IDLE, all counters 0, and all outputs 0.
REQ-026 rst SHALL preset synchronizer and history flops to 1 (idle line).
REQ-027 rst mid-frame SHALL abort the frame with no packet_done or load_buffer; the next start edge after release SHALL be received normally.

Structure
REQ-028 The state enum type and the CLKS_PER_BIT default constant SHALL live in shared package rcv_pkg.
REQ-029 The clock and bit counters SHALL be one sub-module, rcv_timer, with clear, enable, rollover value, and strobe output.

Verification
REQ-030 CLKS_PER_BIT=10, frame 0xA5 stop=1: 9 shift_strobe pulses 10 clocks apart, the first 10 clocks after the start sample; packet_done, then load_buffer next cycle; data_ready=1, framing_error=0.
REQ-031 serial_in low for 3 clocks then high: state returns IDLE, zero shift_strobe pulses, all outputs 0.
REQ-032 Frame with stop=0: packet_done pulses, framing_error=1, no load_buffer, data_ready unchanged; framing_error clears at the next valid start.
REQ-033 Two good frames without data_read: overrun_error=1 after the second load_buffer; data_read pulse -> data_ready=0, overrun_error=0.
REQ-034 rst asserted at the 4th shift_strobe: outputs 0 same cycle; a following 0x3C frame is received with 9 strobes and load_buffer.
REQ-035 data_read coincident with load_buffer while data_ready=1: data_ready stays 1, overrun_error stays 0.
